// File: rtl/mult68_rr_arbiter.sv
// Round-robin front end for a shared GF(2^8) multiply-by-0x68 unit.
// Requesters present bytes with valid/ready; the winner's product lands in a
// one-entry result register tagged with the winning requester index.

// Combinational y = 0x68 * x over GF(2^8), reduction polynomial 0x11B.
module mult_68 (
    input  logic [7:0] x,
    output logic [7:0] y
);
    logic [6:0][7:0] xt;

    // xt[k] = x * 2^k; 0x68 = 2^6 + 2^5 + 2^3
    always_comb begin
        xt[0] = x;
        for (int k = 1; k < 7; k++) begin
            xt[k] = {xt[k-1][6:0], 1'b0} ^ (xt[k-1][7] ? 8'h1B : 8'h00);
        end
        y = xt[3] ^ xt[5] ^ xt[6];
    end
endmodule

module mult68_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready,
    output logic              busy,
    output logic [CNTW-1:0]   grant_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt;
    logic           found;
    logic           can_accept;
    logic           xfer;
    logic [7:0]     operand;
    logic [7:0]     product;

    assign rsp_valid  = (state == FULL);
    assign can_accept = !rsp_valid || rsp_ready;
    assign busy       = rsp_valid || (|req_valid);

    // First valid requester scanning upward from ptr, wrapping at NREQ
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
    end

    // Ready goes only to the winner, and never while reset is held
    always_comb begin
        req_ready = '0;
        xfer      = !rst && found && can_accept;
        if (xfer) req_ready[gnt] = 1'b1;
        operand = req_data[8*int'(gnt) +: 8];
    end

    mult_68 u_mult (
        .x (operand),
        .y (product)
    );

    // Result register, pointer and grant counter; ptr moves only on a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            rsp_data  <= 8'h00;
            rsp_id    <= '0;
            ptr       <= '0;
            grant_cnt <= '0;
        end else if (xfer) begin
            state    <= FULL;
            rsp_data <= product;
            rsp_id   <= gnt;
            ptr      <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
            if (grant_cnt != '1) grant_cnt <= grant_cnt + 1'b1;
        end else if (rsp_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_mult68_rr_arbiter.sv
// Bench for mult68_rr_arbiter: directed sequences, a cycle-level reference
// model checked every negedge, and literal expectations pinning the model.
module tb_mult68_rr_arbiter;
    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic        rsp_ready = 1'b0;
    logic [3:0]  req_ready, req_ready4;
    logic        rsp_valid, rsp_valid4;
    logic [7:0]  rsp_data, rsp_data4;
    logic [1:0]  rsp_id, rsp_id4;
    logic        busy, busy4;
    logic [15:0] grant_cnt;
    logic [3:0]  grant_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult68_rr_arbiter #(.NREQ(NREQ), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy), .grant_cnt(grant_cnt)
    );

    mult68_rr_arbiter #(.NREQ(NREQ), .CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready4), .rsp_valid(rsp_valid4), .rsp_data(rsp_data4),
        .rsp_id(rsp_id4), .rsp_ready(rsp_ready), .busy(busy4), .grant_cnt(grant_cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Schoolbook carry-less multiply, then polynomial long division by 0x11B
    function automatic logic [7:0] gf(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Reference state
    bit   m_full = 0;
    logic [7:0] m_data = 8'h00;
    int   m_id = 0, m_ptr = 0, m_cnt = 0, m_cnt4 = 0;

    // Compare process: outputs against the model every negedge
    always @(negedge clk) begin
        int g;
        logic [3:0] er;
        g  = pick(req_valid, m_ptr);
        er = (!rst && g >= 0 && (!m_full || rsp_ready)) ? 4'(1 << g) : 4'h0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("busy", 32'(busy), 32'(m_full || (|req_valid)));
        chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
        chk("grant_cnt4", 32'(grant_cnt4), 32'(m_cnt4));
    end

    // Model update on the edge, from the inputs the DUT also samples
    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_full = 0; m_data = 8'h00; m_id = 0; m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            g = pick(req_valid, m_ptr);
            if (g >= 0 && (!m_full || rsp_ready)) begin
                m_full = 1;
                m_data = gf(8'h68, req_data[8*g +: 8]);
                m_id   = g;
                m_ptr  = (g + 1) % NREQ;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end else if (rsp_ready) begin
                m_full = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Model pins
        chk("gf_x01", 32'(gf(8'h68, 8'h01)), 32'h68);
        chk("gf_x02", 32'(gf(8'h68, 8'h02)), 32'hD0);
        chk("gf_x03", 32'(gf(8'h68, 8'h03)), 32'hB8);
        chk("gf_x80", 32'(gf(8'h68, 8'h80)), 32'h8A);
        chk("gf_x00", 32'(gf(8'h68, 8'h00)), 32'h00);

        repeat (2) step();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_grant_cnt", 32'(grant_cnt), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;

        // 1: single request from req0
        rsp_ready = 1'b1; req_valid = 4'b0001; req_data[7:0] = 8'h01;
        step();
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_data", 32'(rsp_data), 32'h68);
        chk("t1_id", 32'(rsp_id), 32'h0);
        chk("t1_cnt", 32'(grant_cnt), 32'h1);
        req_valid = '0;
        step();
        chk("t1_drain", 32'(rsp_valid), 32'h0);

        // 2: all valid; ptr is 1 after test 1 so ids go 1,2,3,0,...
        req_data = {4{8'h02}}; req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_id", 32'(rsp_id), 32'((1 + k) % 4));
            chk("t2_data", 32'(rsp_data), 32'hD0);
        end
        req_valid = '0;
        step();

        // 3: req1 accepted, then stall with req2 waiting
        req_valid = 4'b0010; req_data[15:8] = 8'h03;
        step();
        chk("t3_data", 32'(rsp_data), 32'hB8);
        req_valid = 4'b0100; rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_hold_data", 32'(rsp_data), 32'hB8);
            chk("t3_hold_id", 32'(rsp_id), 32'h1);
            chk("t3_hold_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_release_ready", 32'(req_ready), 32'h4);
        step();
        chk("t3_release_id", 32'(rsp_id), 32'h2);

        // 4: req3 alone three times, then all -> req0 wins
        req_valid = 4'b1000; req_data[31:24] = 8'h05;
        repeat (3) step();
        req_valid = 4'hF;
        step();
        chk("t4_id", 32'(rsp_id), 32'h0);
        req_valid = '0;
        step();

        // 5: reset while FULL with everyone requesting
        req_valid = 4'hF; rsp_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", 32'(req_ready), 32'h0);
        step();
        chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t5_cnt", 32'(grant_cnt), 32'h0);
        rst = 1'b0; rsp_ready = 1'b1;
        step();
        chk("t5_first_id", 32'(rsp_id), 32'h0);
        req_valid = '0;
        step();

        // 6: every operand through req2
        req_valid = 4'b0100;
        for (int x = 0; x < 256; x++) begin
            req_data[23:16] = 8'(x);
            step();
            if (x == 8'h80) chk("t6_x80", 32'(rsp_data), 32'h8A);
            if (x == 0) chk("t6_x00", 32'(rsp_data), 32'h00);
        end
        req_valid = '0;
        step();
        chk("t6_cnt4_sat", 32'(grant_cnt4), 32'hF);
        chk("t6_cnt16", 32'(grant_cnt), 32'd257);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
